// File: rtl/sdram_req_queue.sv
// sdram_req_queue: buffers host read/write requests and issues them one at a time to the SDRAM controller,
// holding each enable until the controller goes busy and returning read data on a pulse.
module sdram_req_queue #(
    parameter int HADDR_WIDTH = 24,
    parameter int DEPTH = 4,
    parameter int AW = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [HADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [15:0]            rsp_data,
    output logic [AW:0]            level,
    output logic                   idle,
    output logic [HADDR_WIDTH-1:0] ctl_wr_addr,
    output logic [15:0]            ctl_wr_data,
    output logic                   ctl_wr_enable,
    output logic [HADDR_WIDTH-1:0] ctl_rd_addr,
    output logic                   ctl_rd_enable,
    input  logic [15:0]            ctl_rd_data,
    input  logic                   ctl_rd_ready,
    input  logic                   ctl_busy
);
    typedef enum logic [1:0] {Q_IDLE, Q_ISSUE, Q_WAIT} state_t;

    state_t state, state_nx;
    logic [HADDR_WIDTH+16:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [HADDR_WIDTH-1:0] iss_addr;
    logic [15:0] iss_wdata;
    logic iss_we, done, push, pop, rd_take;

    assign req_ready = level != (AW+1)'(DEPTH);
    assign push = req_valid && req_ready;
    assign pop = state == Q_IDLE && level != '0;
    assign idle = state == Q_IDLE && level == '0;
    assign rd_take = state == Q_WAIT && !iss_we && !done && ctl_rd_ready;
    assign ctl_wr_addr = iss_addr;
    assign ctl_rd_addr = iss_addr;
    assign ctl_wr_data = iss_wdata;
    // Enables drop combinationally on busy so the controller never samples a second request.
    assign ctl_wr_enable = state == Q_ISSUE && iss_we && !ctl_busy;
    assign ctl_rd_enable = state == Q_ISSUE && !iss_we && !ctl_busy;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {req_we, req_addr, req_wdata};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            iss_we <= 1'b0;
            iss_addr <= '0;
            iss_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            done <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                {iss_we, iss_addr, iss_wdata} <= mem[rd_ptr];
            end
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
            rsp_valid <= rd_take;
            if (rd_take) rsp_data <= ctl_rd_data;
            done <= pop ? 1'b0 : done | rd_take;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= Q_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            Q_IDLE:  state_nx = level != '0 ? Q_ISSUE : Q_IDLE;
            Q_ISSUE: state_nx = ctl_busy ? Q_WAIT : Q_ISSUE;
            Q_WAIT:  state_nx = !ctl_busy && (iss_we || done || rd_take) ? Q_IDLE : Q_WAIT;
            default: state_nx = Q_IDLE;
        endcase
    end
endmodule

// File: tb/tb_sdram_req_queue.sv
// tb_sdram_req_queue: directed and randomized checks of sdram_req_queue against a queue-based
// reference model and a behavioural SDRAM controller with refresh stalls and variable busy time.
module tb_sdram_req_queue;
    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [15:0] data;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_we = 1'b0;
    logic [23:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic req_ready, rsp_valid, idle, ctl_wr_enable, ctl_rd_enable;
    logic [15:0] rsp_data, ctl_wr_data;
    logic [2:0] level;
    logic [23:0] ctl_wr_addr, ctl_rd_addr;
    logic [15:0] ctl_rd_data = '0;
    logic ctl_rd_ready = 1'b0;
    logic ctl_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    logic stall = 1'b0;
    logic hold = 1'b0;
    logic [15:0] cmem [logic [23:0]];
    logic        obs_we [256];
    logic [23:0] obs_addr [256];
    logic [15:0] obs_wdata [256];
    logic [15:0] obs_rsp [256];
    int n_iss = 0;
    int n_rsp = 0;
    int viol = 0;
    int cnt = 0;
    logic tail = 1'b0;
    logic op_rd = 1'b0;
    logic [23:0] op_addr = '0;
    logic en, prev_en = 1'b0, prev_rsp = 1'b0;
    logic [23:0] prev_addr = '0;

    req_t ref_q [$];
    logic [15:0] exp_rsp [$];
    logic [15:0] ref_mem [logic [23:0]];
    int iss_rd = 0;
    int rsp_rd = 0;

    sdram_req_queue #(.HADDR_WIDTH(24), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .level(level), .idle(idle),
        .ctl_wr_addr(ctl_wr_addr), .ctl_wr_data(ctl_wr_data), .ctl_wr_enable(ctl_wr_enable),
        .ctl_rd_addr(ctl_rd_addr), .ctl_rd_enable(ctl_rd_enable),
        .ctl_rd_data(ctl_rd_data), .ctl_rd_ready(ctl_rd_ready), .ctl_busy(ctl_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dflt(input logic [23:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Controller model: acts 2 time units after each falling edge, records what it accepted and what came back.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            ctl_rd_ready = 1'b0;
            if (!rst_n) begin
                ctl_busy = 1'b0;
                cnt = 0;
                tail = 1'b0;
                prev_en = 1'b0;
                prev_rsp = 1'b0;
            end else begin
                en = ctl_wr_enable || ctl_rd_enable;
                if (ctl_wr_enable && ctl_rd_enable) viol++;
                if (ctl_busy && en) viol++;
                if (en && prev_en && (ctl_rd_addr != prev_addr || ctl_wr_addr != ctl_rd_addr)) viol++;
                prev_en = en;
                prev_addr = ctl_rd_addr;
                if (rsp_valid) begin
                    if (prev_rsp) viol++;
                    if (n_rsp < 256) obs_rsp[n_rsp] = rsp_data;
                    n_rsp++;
                end
                prev_rsp = rsp_valid;
                if (tail) begin
                    ctl_busy = 1'b0;
                    tail = 1'b0;
                end else if (cnt != 0) begin
                    if (!hold) cnt--;
                    if (cnt == 0) begin
                        if (op_rd) begin
                            ctl_rd_ready = 1'b1;
                            ctl_rd_data = cmem.exists(op_addr) ? cmem[op_addr] : dflt(op_addr);
                            if ($urandom_range(0, 1) == 1) tail = 1'b1;
                            else ctl_busy = 1'b0;
                        end else ctl_busy = 1'b0;
                    end
                end else if (en && !stall) begin
                    if (n_iss < 256) begin
                        obs_we[n_iss] = ctl_wr_enable;
                        obs_addr[n_iss] = ctl_rd_addr;
                        obs_wdata[n_iss] = ctl_wr_data;
                    end
                    n_iss++;
                    op_rd = ctl_rd_enable;
                    op_addr = ctl_rd_addr;
                    if (ctl_wr_enable) cmem[ctl_wr_addr] = ctl_wr_data;
                    ctl_busy = 1'b1;
                    cnt = $urandom_range(1, 4);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [23:0] a, input logic [15:0] d);
        int w = 0;
        req_t r;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        while (!req_ready && w < 300) begin
            @(negedge clk);
            w++;
            if (w > 4) stall = 1'b0;
        end
        chk("push_accept", req_ready, 1'b1);
        r.we = we;
        r.addr = a;
        r.data = d;
        ref_q.push_back(r);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(idle && !ctl_busy) && w < 2000);
        repeat (2) @(negedge clk);
        chk("idle", idle, 1'b1);
    endtask

    // Expected issue order is acceptance order; memory effects apply as each request reaches the controller.
    task automatic drain();
        req_t e;
        while (iss_rd < n_iss) begin
            if (ref_q.size() == 0) begin
                chk("iss_extra", n_iss, iss_rd);
                iss_rd = n_iss;
            end else begin
                e = ref_q.pop_front();
                chk("iss_we", obs_we[iss_rd], e.we);
                chk("iss_addr", obs_addr[iss_rd], e.addr);
                if (e.we) begin
                    chk("iss_wdata", obs_wdata[iss_rd], e.data);
                    ref_mem[e.addr] = e.data;
                end else exp_rsp.push_back(ref_mem.exists(e.addr) ? ref_mem[e.addr] : dflt(e.addr));
                iss_rd++;
            end
        end
        while (rsp_rd < n_rsp) begin
            if (exp_rsp.size() == 0) begin
                chk("rsp_extra", n_rsp, rsp_rd);
                rsp_rd = n_rsp;
            end else begin
                chk("rsp_data", obs_rsp[rsp_rd], exp_rsp.pop_front());
                rsp_rd++;
            end
        end
    endtask

    initial begin
        int base, ibase, w;
        repeat (3) @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_idle", idle, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_wr_en", ctl_wr_enable, 1'b0);
        chk("rst_rd_en", ctl_rd_enable, 1'b0);
        chk("rst_wr_addr", ctl_wr_addr, 0);
        chk("rst_wr_data", ctl_wr_data, 0);
        rst_n = 1'b1;

        // Single write: enable two cycles after accept, held through a stall, dropped when busy rises.
        base = n_rsp;
        stall = 1'b1;
        push(1'b1, 24'h012345, 16'hBEEF);
        @(negedge clk);
        chk("lat1_level", level, 1);
        chk("lat1_wr_en", ctl_wr_enable, 1'b0);
        @(negedge clk);
        chk("lat2_wr_en", ctl_wr_enable, 1'b1);
        chk("lat2_rd_en", ctl_rd_enable, 1'b0);
        chk("lat2_wr_addr", ctl_wr_addr, 24'h012345);
        chk("lat2_wr_data", ctl_wr_data, 16'hBEEF);
        repeat (2) @(negedge clk);
        chk("held_wr_en", ctl_wr_enable, 1'b1);
        stall = 1'b0;
        #3;
        chk("busy_rise", ctl_busy, 1'b1);
        chk("wr_en_drop", ctl_wr_enable, 1'b0);
        wait_idle();
        drain();
        chk("write_no_rsp", n_rsp, base);

        // Read returns data as a single-cycle pulse, then held.
        base = n_rsp;
        push(1'b1, 24'h000010, 16'hA5A5);
        push(1'b0, 24'h000010, 16'h0000);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!rsp_valid && w < 200);
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_rsp_data", rsp_data, 16'hA5A5);
        @(negedge clk);
        chk("rd_rsp_pulse", rsp_valid, 1'b0);
        chk("rd_rsp_hold", rsp_data, 16'hA5A5);
        wait_idle();
        drain();
        chk("rd_rsp_count", n_rsp - base, 1);

        // Stalled controller: FIFO fills to DEPTH behind the stuck issue, the next push is held off.
        ibase = n_iss;
        stall = 1'b1;
        for (int i = 0; i < 5; i++)
            push(1'($urandom_range(0, 1)), 24'($urandom_range(0, 7)) << 4, 16'($urandom));
        @(negedge clk);
        chk("full_level", level, 4);
        chk("full_ready", req_ready, 1'b0);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 24'h000050;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_ready", req_ready, 1'b0);
            chk("held_level", level, 4);
        end
        stall = 1'b0;
        w = 0;
        while (!req_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("late_accept", req_ready, 1'b1);
        ref_q.push_back('{1'b0, 24'h000050, 16'h0000});
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_idle();
        drain();
        chk("full_issued", n_iss - ibase, 6);

        // Refresh: read enable held 12 cycles with a stable address, then served once.
        base = n_rsp;
        stall = 1'b1;
        push(1'b0, 24'h000020, 16'h0000);
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("refresh_rd_en", ctl_rd_enable, 1'b1);
            chk("refresh_rd_addr", ctl_rd_addr, 24'h000020);
        end
        stall = 1'b0;
        wait_idle();
        drain();
        chk("refresh_rsp_count", n_rsp - base, 1);

        // Mixed write/read sequence.
        base = n_rsp;
        push(1'b1, 24'h000100, 16'h1111);
        push(1'b0, 24'h000100, 16'h0000);
        push(1'b1, 24'h000200, 16'h2222);
        push(1'b0, 24'h000200, 16'h0000);
        wait_idle();
        drain();
        chk("mixed_count", n_rsp - base, 2);
        chk("mixed_rsp0", obs_rsp[base], 16'h1111);
        chk("mixed_rsp1", obs_rsp[base+1], 16'h2222);

        // Reset during a read wait with two entries queued: everything is discarded silently.
        base = n_rsp;
        ibase = n_iss;
        hold = 1'b1;
        push(1'b0, 24'h000300, 16'h0000);
        push(1'b1, 24'h000310, 16'h3333);
        push(1'b0, 24'h000310, 16'h0000);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!ctl_busy && w < 200);
        repeat (2) @(negedge clk);
        chk("prerst_level", level, 2);
        chk("prerst_busy", ctl_busy, 1'b1);
        drain();
        ref_q.delete();
        exp_rsp.delete();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_level", level, 0);
        chk("midrst_wr_en", ctl_wr_enable, 1'b0);
        chk("midrst_rd_en", ctl_rd_enable, 1'b0);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_idle", idle, 1'b1);
        rst_n = 1'b1;
        hold = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrst_no_rsp", n_rsp, base);
        chk("midrst_issued", n_iss - ibase, 1);
        drain();

        // Randomized traffic with random refresh stalls and gaps.
        for (int i = 0; i < 60; i++) begin
            stall = $urandom_range(0, 5) == 0;
            push(1'($urandom_range(0, 1)), 24'($urandom_range(0, 7)) << 4, 16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        stall = 1'b0;
        wait_idle();
        drain();

        chk("ref_q_left", ref_q.size(), 0);
        chk("exp_rsp_left", exp_rsp.size(), 0);
        chk("ctl_protocol", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
